// File: rtl/alu_muldiv.sv
// RV32I ALU plus RV M-extension with handshaked iterative multiply/divide.
// ALU_MULDIV_FAST_MUL_EN: single-cycle combinational multiply; divide stays iterative.
// state | meaning
// IDLE  | ready for a request
// BUSY  | WIDTH shift-add / restoring-divide steps
// DONE  | result valid, waiting for out_ready
module alu_muldiv #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t               state_q, state_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2:0]           fn_q, fn_d;
  logic                 negq_q, negq_d, negr_q, negr_d;
  logic [WIDTH-1:0]     result_q, result_d;

  logic                 accept, is_div, sgn_a_en, sgn_b_en, sgn_a, sgn_b;
  logic                 div_zero, div_ovf, mul_fast;
  logic [WIDTH-1:0]     mag_a, mag_b, base_res, fast_res, quot_s, rem_s, fin_res;
  logic [WIDTH:0]       sum, rs, diff;
  logic [2*WIDTH-1:0]   mul_nxt, div_nxt, step, prod_s;

  assign accept    = in_valid && (state_q == S_IDLE) && !flush;
  assign is_div    = op[2];
  assign sgn_a_en  = is_div ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
  assign sgn_b_en  = is_div ? ~op[0] : (op[1:0] == 2'b01);
  assign sgn_a     = sgn_a_en & op_a[WIDTH-1];
  assign sgn_b     = sgn_b_en & op_b[WIDTH-1];
  assign mag_a     = sgn_a ? ('0 - op_a) : op_a;
  assign mag_b     = sgn_b ? ('0 - op_b) : op_b;
  assign div_zero  = (op_b == '0);
  assign div_ovf   = ~op[0] && (op_a == MIN_NEG) && (op_b == '1);

  always_comb begin
    base_res = '0;
    case (op[3:0])
      4'b0000: base_res = op_a + op_b;
      4'b1000: base_res = op_a - op_b;
      4'b0001: base_res = op_a << op_b[SHW-1:0];
      4'b0010: base_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'b0011: base_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
      4'b0100: base_res = op_a ^ op_b;
      4'b0101: base_res = op_a >> op_b[SHW-1:0];
      4'b1101: base_res = $unsigned($signed(op_a) >>> op_b[SHW-1:0]);
      4'b0110: base_res = op_a | op_b;
      4'b0111: base_res = op_a & op_b;
      4'b1110: base_res = op_a;
      4'b1111: base_res = op_b;
      default: base_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_FAST_MUL_EN
  logic signed [WIDTH:0]     fa, fb;
  logic signed [2*WIDTH-1:0] fp;
  assign fa       = {sgn_a_en & op_a[WIDTH-1], op_a};
  assign fb       = {sgn_b_en & op_b[WIDTH-1], op_b};
  assign fp       = (2*WIDTH)'(fa) * (2*WIDTH)'(fb);
  assign fast_res = (op[1:0] == 2'b00) ? fp[WIDTH-1:0] : fp[2*WIDTH-1:WIDTH];
  assign mul_fast = 1'b1;
`else
  assign fast_res = '0;
  assign mul_fast = 1'b0;
`endif

  // acc_q = {partial product | remainder, multiplier | dividend->quotient}
  assign sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_nxt = {sum, acc_q[WIDTH-1:1]};
  assign rs      = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign diff    = rs - {1'b0, opb_q};
  assign div_nxt = {diff[WIDTH] ? rs[WIDTH-1:0] : diff[WIDTH-1:0],
                    acc_q[WIDTH-2:0], ~diff[WIDTH]};
  assign step    = fn_q[2] ? div_nxt : mul_nxt;

  assign prod_s  = negq_q ? ('0 - step) : step;
  assign quot_s  = negq_q ? ('0 - step[WIDTH-1:0]) : step[WIDTH-1:0];
  assign rem_s   = negr_q ? ('0 - step[2*WIDTH-1:WIDTH]) : step[2*WIDTH-1:WIDTH];
  assign fin_res = fn_q[2] ? (fn_q[1] ? rem_s : quot_s)
                           : ((fn_q[1:0] == 2'b00) ? prod_s[WIDTH-1:0]
                                                   : prod_s[2*WIDTH-1:WIDTH]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    fn_d     = fn_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          fn_d    = op[2:0];
          state_d = S_DONE;
          if (!op[4]) begin
            result_d = base_res;
          end else if (is_div && div_zero) begin
            result_d = op[1] ? op_a : '1;
          end else if (is_div && div_ovf) begin
            result_d = op[1] ? '0 : MIN_NEG;
          end else if (!is_div && mul_fast) begin
            result_d = fast_res;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            opb_d   = mag_b;
            negq_d  = sgn_a ^ sgn_b;
            negr_d  = sgn_a;
            cnt_d   = '0;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        acc_d = step;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH-1)) begin
          result_d = fin_res;
          cnt_d    = '0;
          state_d  = S_DONE;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      fn_q     <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      fn_q     <= fn_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: vector table plus handshake, flush and reset sequences.
module tb_alu_muldiv;

`ifdef ALU_MULDIV_FAST_MUL_EN
  localparam int MLAT = 1;
`else
  localparam int MLAT = 33;
`endif
  localparam int DLAT = 33;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [4:0]  op;
  logic [31:0] op_a, op_b, result;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       nm;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          lat;
    string       nm;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic addv(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] e, input int l, input string nm);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.exp = e; v.lat = l; v.nm = nm;
    vecs.push_back(v);
  endtask

  // Drive one request, wait (bounded) for out_valid, then compare against the scoreboard.
  task automatic issue_and_wait(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] e, input int l, input string nm);
    exp_t x;
    int   lat;
    x.res = e; x.lat = l; x.nm = nm;
    sb.push_back(x);
    @(negedge clk);
    op = o; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    x = sb.pop_front();
    chk({x.nm, " latency"}, 32'(lat), 32'(x.lat));
    chk({x.nm, " result"}, result, x.res);
  endtask

  task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input int l, input string nm);
    issue_and_wait(o, a, b, e, l, nm);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] held;
    bit          seen;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; op_a = '0; op_b = '0;

    addv(5'b00000, 32'd3,         32'd4,         32'd7,         1, "ADD");
    addv(5'b01000, 32'd5,         32'd7,         32'hFFFFFFFE,  1, "SUB");
    addv(5'b00001, 32'd1,         32'h21,        32'd2,         1, "SLL");
    addv(5'b00010, 32'hFFFFFFFF,  32'd1,         32'd1,         1, "SLT");
    addv(5'b00011, 32'hFFFFFFFF,  32'd1,         32'd0,         1, "SLTU");
    addv(5'b00100, 32'h0000F0F0,  32'h0000FF00,  32'h00000FF0,  1, "XOR");
    addv(5'b00101, 32'h80000000,  32'h24,        32'h08000000,  1, "SRL");
    addv(5'b01101, 32'h80000000,  32'h24,        32'hF8000000,  1, "SRA");
    addv(5'b00110, 32'h00000F00,  32'h000000F0,  32'h00000FF0,  1, "OR");
    addv(5'b00111, 32'h0000FF00,  32'h00000FF0,  32'h00000F00,  1, "AND");
    addv(5'b01110, 32'h12345678,  32'h9ABCDEF0,  32'h12345678,  1, "PASSA");
    addv(5'b01111, 32'h12345678,  32'h9ABCDEF0,  32'h9ABCDEF0,  1, "PASSB");
    addv(5'b01001, 32'h12345678,  32'h9ABCDEF0,  32'h00000000,  1, "UNDEF");
    addv(5'b10000, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  MLAT, "MUL");
    addv(5'b10001, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000,  MLAT, "MULH");
    addv(5'b10010, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF,  MLAT, "MULHSU");
    addv(5'b10011, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  MLAT, "MULHU");
    addv(5'b11000, 32'd6,         32'd7,         32'd42,        MLAT, "MUL_op3");
    addv(5'b10001, 32'h80000000,  32'd2,         32'hFFFFFFFF,  MLAT, "MULH_neg");
    addv(5'b10011, 32'h80000000,  32'd2,         32'h00000001,  MLAT, "MULHU_big");
    addv(5'b10100, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1, "DIV_ovf");
    addv(5'b10110, 32'h80000000,  32'hFFFFFFFF,  32'h00000000,  1, "REM_ovf");
    addv(5'b10101, 32'd7,         32'd0,         32'hFFFFFFFF,  1, "DIVU_z");
    addv(5'b10111, 32'd7,         32'd0,         32'd7,         1, "REMU_z");
    addv(5'b10100, 32'd7,         32'd0,         32'hFFFFFFFF,  1, "DIV_z");
    addv(5'b10110, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFF9,  1, "REM_z");
    addv(5'b10100, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  DLAT, "DIV");
    addv(5'b10110, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  DLAT, "REM");
    addv(5'b10100, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  DLAT, "DIV_nb");
    addv(5'b10110, 32'd7,         32'hFFFFFFFE,  32'd1,         DLAT, "REM_nb");
    addv(5'b10101, 32'd100,       32'd7,         32'd14,        DLAT, "DIVU");
    addv(5'b10111, 32'd100,       32'd7,         32'd2,         DLAT, "REMU");
    addv(5'b10101, 32'h80000000,  32'hFFFFFFFF,  32'd0,         DLAT, "DIVU_big");
    addv(5'b10111, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  DLAT, "REMU_big");

    #2;
    chk("rst in_ready",  32'(in_ready),  32'd1);
    chk("rst busy",      32'(busy),      32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst result",    result,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].nm);

    // Backpressure: result held while out_ready low, new request ignored.
    out_ready = 1'b0;
    issue_and_wait(5'b10100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, DLAT, "hold DIV");
    held = 32'hFFFFFFFD;
    @(negedge clk);
    op = 5'b00000; op_a = 32'd1; op_b = 32'd1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold result",    result,          held);
      chk("hold out_valid", 32'(out_valid),  32'd1);
      chk("hold in_ready",  32'(in_ready),   32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold release in_ready",  32'(in_ready),  32'd1);
    chk("hold release out_valid", 32'(out_valid), 32'd0);

    // Flush mid-BUSY.
    @(negedge clk);
    op = 5'b10101; op_a = 32'd100; op_b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush in_ready",  32'(in_ready),  32'd1);
    chk("flush busy",      32'(busy),      32'd0);
    chk("flush result",    result,         held);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush out_valid never", 32'(seen), 32'd0);
    run_op(5'b00000, 32'd3, 32'd4, 32'd7, 1, "post-flush ADD");

    // Request with flush in the same cycle is dropped.
    @(negedge clk);
    op = 5'b00000; op_a = 32'd9; op_b = 32'd9; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush+valid busy",   32'(busy),   32'd0);
    chk("flush+valid result", result,      32'd7);

    // Async reset mid-BUSY.
    @(negedge clk);
    op = 5'b10101; op_a = 32'd100; op_b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst busy out_valid", 32'(out_valid), 32'd0);
    chk("rst busy result",    result,         32'd0);
    chk("rst busy in_ready",  32'(in_ready),  32'd1);
    chk("rst busy busy",      32'(busy),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset mid-DONE.
    out_ready = 1'b0;
    @(negedge clk);
    op = 5'b00000; op_a = 32'd1; op_b = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("done out_valid", 32'(out_valid), 32'd1);
    chk("done result",    result,         32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst done out_valid", 32'(out_valid), 32'd0);
    chk("rst done result",    result,         32'd0);
    chk("rst done in_ready",  32'(in_ready),  32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(5'b00000, 32'd3, 32'd4, 32'd7, 1, "post-reset ADD");
    run_op(5'b10111, 32'd100, 32'd7, 32'd2, DLAT, "post-reset REMU");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
